// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS memory bridge: access sizes, FSM states and
// the alignment rule used by both the top and the lane steering logic.
package mips_mem_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] SEL_WORD = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_BYTE = 2'b10;
    localparam logic [1:0] SEL_ILL  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    // Word accesses need offset 0, halves need an even offset, bytes go anywhere.
    function automatic logic access_illegal(input logic [1:0] sel, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (sel)
            SEL_WORD: bad = (off != 2'b00);
            SEL_HALF: bad = off[0];
            SEL_BYTE: bad = 1'b0;
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mips_mem_bridge_lane_steer.sv
// Combinational byte-lane steering: byte enables and store replication from the
// live core request, load extraction and zero-extension from the captured one.
module mips_lane_steer
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            i_sel,
    input  logic [1:0]            i_off,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [LANES-1:0]      o_be,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_illegal,
    input  logic [1:0]            i_rsel,
    input  logic [1:0]            i_roff,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] w_rshift;

    assign o_illegal = access_illegal(i_sel, i_off);

    always_comb begin
        o_be    = '0;
        o_wdata = i_wdata;
        case (i_sel)
            SEL_WORD: o_be = 4'b1111;
            SEL_HALF: begin
                o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            SEL_BYTE: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            default: o_be = '0;
        endcase
    end

    // Lane n sits at bits 8n+7:8n, so shifting down by 8*offset right-justifies it.
    assign w_rshift = i_rdata >> {i_roff, 3'b000};

    always_comb begin
        o_rdata = '0;
        case (i_rsel)
            SEL_WORD: o_rdata = i_rdata;
            SEL_HALF: o_rdata = {16'h0000, w_rshift[15:0]};
            SEL_BYTE: o_rdata = {24'h000000, w_rshift[7:0]};
            default:  o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mips_mem_bridge.sv
// Bridge from the multi-cycle MIPS core strobes to a word-wide req/ack memory,
// with alignment checking, ack timeout and a stall back to the core.
module mips_mem_bridge
    import mips_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDRESS_WIDTH-1:0] CPU_ADDR,
    input  logic                     CPU_WS,
    input  logic                     CPU_OE,
    input  logic [1:0]               RAM_SEL,
    input  logic [DATA_WIDTH-1:0]    CPU_WDATA,
    output logic [DATA_WIDTH-1:0]    CPU_RDATA,
    output logic                     STALL,
    output logic                     ALIGN_ERR,
    output logic                     BUS_ERR,
    output logic                     MEM_REQ,
    output logic                     MEM_WE,
    output logic [ADDRESS_WIDTH-3:0] MEM_ADDR,
    output logic [LANES-1:0]         MEM_BE,
    output logic [DATA_WIDTH-1:0]    MEM_WDATA,
    input  logic                     MEM_ACK,
    input  logic [DATA_WIDTH-1:0]    MEM_RDATA,
    output logic [1:0]               DBG_STATE
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]               r_state;
    logic [7:0]               r_cnt;
    logic [1:0]               r_sel;
    logic [1:0]               r_off;
    logic                     r_req;
    logic                     r_we;
    logic [ADDRESS_WIDTH-3:0] r_addr;
    logic [LANES-1:0]         r_be;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_stall;
    logic                     r_align_err;
    logic                     r_bus_err;

    logic                     w_req;
    logic                     w_illegal;
    logic [LANES-1:0]         w_be;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic [DATA_WIDTH-1:0]    w_rdata_ext;

    assign w_req = CPU_WS | CPU_OE;

    mips_lane_steer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_steer (
        .i_sel     (RAM_SEL),
        .i_off     (CPU_ADDR[1:0]),
        .i_wdata   (CPU_WDATA),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_illegal (w_illegal),
        .i_rsel    (r_sel),
        .i_roff    (r_off),
        .i_rdata   (MEM_RDATA),
        .o_rdata   (w_rdata_ext)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sel       <= SEL_WORD;
            r_off       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_stall     <= 1'b0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_stall <= 1'b1;
                        if (w_illegal) begin
                            r_state     <= ST_ERR;
                            r_align_err <= 1'b1;
                        end else begin
                            // A write strobe wins when both strobes are raised.
                            r_state <= ST_BUSY;
                            r_req   <= 1'b1;
                            r_we    <= CPU_WS;
                            r_addr  <= CPU_ADDR[ADDRESS_WIDTH-1:2];
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_sel   <= RAM_SEL;
                            r_off   <= CPU_ADDR[1:0];
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (MEM_ACK) begin
                        if (!r_we) begin
                            r_rdata <= w_rdata_ext;
                        end
                        r_req   <= 1'b0;
                        r_stall <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_bus_err <= 1'b1;
                        r_req     <= 1'b0;
                        r_stall   <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_ERR: begin
                    r_stall <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_stall <= 1'b0;
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign CPU_RDATA = r_rdata;
    assign STALL     = r_stall;
    assign ALIGN_ERR = r_align_err;
    assign BUS_ERR   = r_bus_err;
    assign MEM_REQ   = r_req;
    assign MEM_WE    = r_we;
    assign MEM_ADDR  = r_addr;
    assign MEM_BE    = r_be;
    assign MEM_WDATA = r_wdata;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Directed bench for mips_mem_bridge: stimulus pushes expected requests, stall
// episodes and error pulses; a negedge monitor pops and compares them.
module tb_mips_mem_bridge;
  import mips_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [AW-1:0] CPU_ADDR = '0;
  logic          CPU_WS = 1'b0;
  logic          CPU_OE = 1'b0;
  logic [1:0]    RAM_SEL = 2'b00;
  logic [DW-1:0] CPU_WDATA = '0;
  logic [DW-1:0] CPU_RDATA;
  logic          STALL;
  logic          ALIGN_ERR;
  logic          BUS_ERR;
  logic          MEM_REQ;
  logic          MEM_WE;
  logic [AW-3:0] MEM_ADDR;
  logic [3:0]    MEM_BE;
  logic [DW-1:0] MEM_WDATA;
  logic          MEM_ACK = 1'b0;
  logic [DW-1:0] MEM_RDATA = '0;
  logic [1:0]    DBG_STATE;

  always #5 CLK = ~CLK;

  mips_mem_bridge #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CPU_ADDR  (CPU_ADDR),
    .CPU_WS    (CPU_WS),
    .CPU_OE    (CPU_OE),
    .RAM_SEL   (RAM_SEL),
    .CPU_WDATA (CPU_WDATA),
    .CPU_RDATA (CPU_RDATA),
    .STALL     (STALL),
    .ALIGN_ERR (ALIGN_ERR),
    .BUS_ERR   (BUS_ERR),
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_BE    (MEM_BE),
    .MEM_WDATA (MEM_WDATA),
    .MEM_ACK   (MEM_ACK),
    .MEM_RDATA (MEM_RDATA),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- scoreboard ----------------
  // request: {we, word addr, be, wdata}; episode: {stall cycles, CPU_RDATA after}
  logic [66:0] exp_req_q[$];
  logic [39:0] exp_ep_q[$];
  logic [1:0]  exp_err_q[$];   // 2'b01 align, 2'b10 bus

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [66:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // ---------------- monitor ----------------
  logic        prev_req = 1'b0;
  logic        prev_stall = 1'b0;
  logic [66:0] held_req = '0;
  int          stall_len = 0;

  always @(negedge CLK) begin
    logic [66:0] obs;
    logic [39:0] ep;
    if (!RST) begin
      prev_req   = 1'b0;
      prev_stall = 1'b0;
      stall_len  = 0;
    end else begin
      obs = {MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA};
      if (MEM_REQ && !prev_req) begin
        if (exp_req_q.size() == 0) unexpected("req", obs);
        else chk("req", obs, exp_req_q.pop_front());
        held_req = obs;
      end else if (MEM_REQ) begin
        chk("req_hold", obs, held_req);
      end
      prev_req = MEM_REQ;

      if (ALIGN_ERR || BUS_ERR) begin
        if (exp_err_q.size() == 0) unexpected("err", {65'd0, BUS_ERR, ALIGN_ERR});
        else chk("err", {65'd0, BUS_ERR, ALIGN_ERR}, {65'd0, exp_err_q.pop_front()});
      end

      if (STALL) begin
        stall_len++;
      end else if (prev_stall) begin
        if (exp_ep_q.size() == 0) begin
          unexpected("stall_episode", 67'(stall_len));
        end else begin
          ep = exp_ep_q.pop_front();
          chk("stall_len", 67'(stall_len), {59'd0, ep[39:32]});
          chk("rdata", {35'd0, CPU_RDATA}, {35'd0, ep[31:0]});
        end
        stall_len = 0;
      end
      prev_stall = STALL;
    end
  end

  // ---------------- driver tasks ----------------
  // ack_at: BUSY cycle (0-based) in which MEM_ACK is raised; -1 = never.
  task automatic access(input logic ws, input logic oe, input logic [1:0] sel,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rd);
    @(posedge CLK); #1;
    CPU_WS = ws; CPU_OE = oe; RAM_SEL = sel; CPU_ADDR = addr; CPU_WDATA = wd;
    @(posedge CLK); #1;
    CPU_WS = 1'b0; CPU_OE = 1'b0;
    if (ack_at >= 0) begin
      for (int i = 0; i < ack_at; i++) begin
        @(posedge CLK); #1;
      end
      MEM_ACK = 1'b1; MEM_RDATA = rd;
      @(posedge CLK); #1;
      MEM_ACK = 1'b0; MEM_RDATA = '0;
      repeat (3) @(posedge CLK);
    end else begin
      repeat (TO + 3) @(posedge CLK);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_mem_req", {66'd0, MEM_REQ}, 67'd0);
    chk("rst_stall", {66'd0, STALL}, 67'd0);
    chk("rst_errs", {65'd0, ALIGN_ERR, BUS_ERR}, 67'd0);
    chk("rst_mem_bus", {MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA}, 67'd0);
    chk("rst_cpu_rdata", {35'd0, CPU_RDATA}, 67'd0);
    chk("rst_state", {65'd0, DBG_STATE}, {65'd0, ST_IDLE});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check_reset_values();
    @(posedge CLK); #3;
    RST = 1'b1;

    // word read 0x10, ack in third BUSY cycle
    exp_req_q.push_back({1'b0, 30'h4, 4'b1111, 32'h0});
    exp_ep_q.push_back({8'd3, 32'hAABBCCDD});
    access(1'b0, 1'b1, SEL_WORD, 32'h10, 32'h0, 2, 32'hAABBCCDD);

    // byte write 0x23, immediate ack
    exp_req_q.push_back({1'b1, 30'h8, 4'b1000, 32'h78787878});
    exp_ep_q.push_back({8'd1, 32'hAABBCCDD});
    access(1'b1, 1'b0, SEL_BYTE, 32'h23, 32'h12345678, 0, 32'h0);

    // half read 0x2
    exp_req_q.push_back({1'b0, 30'h0, 4'b1100, 32'h0});
    exp_ep_q.push_back({8'd2, 32'h0000AABB});
    access(1'b0, 1'b1, SEL_HALF, 32'h2, 32'h0, 1, 32'hAABBCCDD);

    // byte read 0x1
    exp_req_q.push_back({1'b0, 30'h0, 4'b0010, 32'h0});
    exp_ep_q.push_back({8'd1, 32'h000000CC});
    access(1'b0, 1'b1, SEL_BYTE, 32'h1, 32'h0, 0, 32'hAABBCCDD);

    // illegal accesses; ack raised during ERR must be ignored
    exp_err_q.push_back(2'b01);
    exp_ep_q.push_back({8'd1, 32'h000000CC});
    access(1'b0, 1'b1, SEL_WORD, 32'h1, 32'h0, 0, 32'hFFFFFFFF);
    exp_err_q.push_back(2'b01);
    exp_ep_q.push_back({8'd1, 32'h000000CC});
    access(1'b0, 1'b1, SEL_ILL, 32'h0, 32'h0, 0, 32'hFFFFFFFF);
    exp_err_q.push_back(2'b01);
    exp_ep_q.push_back({8'd1, 32'h000000CC});
    access(1'b1, 1'b0, SEL_HALF, 32'h3, 32'h55AA55AA, 0, 32'hFFFFFFFF);

    // half write 0x2
    exp_req_q.push_back({1'b1, 30'h0, 4'b1100, 32'hABCDABCD});
    exp_ep_q.push_back({8'd2, 32'h000000CC});
    access(1'b1, 1'b0, SEL_HALF, 32'h2, 32'h1234ABCD, 1, 32'h0);

    // both strobes: treated as a write
    exp_req_q.push_back({1'b1, 30'h40, 4'b1111, 32'hDEADBEEF});
    exp_ep_q.push_back({8'd1, 32'h000000CC});
    access(1'b1, 1'b1, SEL_WORD, 32'h100, 32'hDEADBEEF, 0, 32'h13572468);

    // timeout: no ack
    exp_req_q.push_back({1'b0, 30'h1, 4'b1111, 32'h0});
    exp_ep_q.push_back({8'd16, 32'h000000CC});
    exp_err_q.push_back(2'b10);
    access(1'b0, 1'b1, SEL_WORD, 32'h4, 32'h0, -1, 32'h0);

    // ack on the last cycle before timeout wins
    exp_req_q.push_back({1'b0, 30'h2, 4'b1111, 32'h0});
    exp_ep_q.push_back({8'd16, 32'h11223344});
    access(1'b0, 1'b1, SEL_WORD, 32'h8, 32'h0, 15, 32'h11223344);

    // byte read from top lane
    exp_req_q.push_back({1'b0, 30'h0, 4'b1000, 32'h0});
    exp_ep_q.push_back({8'd1, 32'h00000099});
    access(1'b0, 1'b1, SEL_BYTE, 32'h3, 32'h0, 0, 32'h99887766);

    // reset in the middle of a transfer
    exp_req_q.push_back({1'b0, 30'h3, 4'b1111, 32'h0});
    @(posedge CLK); #1;
    CPU_OE = 1'b1; RAM_SEL = SEL_WORD; CPU_ADDR = 32'hC;
    @(posedge CLK); #1;
    CPU_OE = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    #1;
    check_reset_values();
    @(posedge CLK); #3;
    RST = 1'b1;

    // new word write after reset completes normally
    exp_req_q.push_back({1'b1, 30'hC, 4'b1111, 32'hCAFEF00D});
    exp_ep_q.push_back({8'd2, 32'h0});
    access(1'b1, 1'b0, SEL_WORD, 32'h30, 32'hCAFEF00D, 1, 32'h0);

    // ---------------- final report ----------------
    repeat (4) @(posedge CLK);
    chk("req_q_drained", 67'(exp_req_q.size()), 67'd0);
    chk("ep_q_drained", 67'(exp_ep_q.size()), 67'd0);
    chk("err_q_drained", 67'(exp_err_q.size()), 67'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
